// File: rtl/score_display.sv
// Binary score to 3-digit decimal on a multiplexed common-anode 7-seg display.
// Latency: 8 cycles to convert after a score change, +1 cycle to segments; no backpressure.
module score_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] score,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       busy
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t      state_q, state_d;
    logic [6:0]  sh_q, sh_d;
    logic [9:0]  bcd_q, bcd_d, bcd_adj;
    logic [2:0]  iter_q, iter_d;
    logic [6:0]  last_q, last_d;
    logic [3:0]  hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
    logic [CW-1:0] cnt_q;
    logic [1:0]  idx_q;
    logic [6:0]  seg_d;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'h40;
            4'd1:    enc = 7'h79;
            4'd2:    enc = 7'h24;
            4'd3:    enc = 7'h30;
            4'd4:    enc = 7'h19;
            4'd5:    enc = 7'h12;
            4'd6:    enc = 7'h02;
            4'd7:    enc = 7'h78;
            4'd8:    enc = 7'h00;
            4'd9:    enc = 7'h10;
            default: enc = 7'h7F;
        endcase
    endfunction

    // The hundreds pair never exceeds 1 for a 7-bit input, so it needs no correction.
    always_comb begin
        bcd_adj = bcd_q;
        if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
        if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        last_d  = last_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        case (state_q)
            IDLE: begin
                if (score != last_q) begin
                    sh_d    = score;
                    last_d  = score;
                    bcd_d   = '0;
                    iter_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d  = {bcd_adj[8:0], sh_q[6]};
                sh_d   = {sh_q[5:0], 1'b0};
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd6) state_d = LOAD;
            end
            LOAD: begin
                hund_d  = {2'b00, bcd_q[9:8]};
                tens_d  = bcd_q[7:4];
                ones_d  = bcd_q[3:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
            last_q  <= '0;
            hund_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
            last_q  <= last_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
        end
    end

    assign busy = (state_q != IDLE);

    always_comb begin
        seg_d = 7'h7F;
        case (idx_q)
            2'd0:    seg_d = enc(ones_q);
            2'd1:    seg_d = (hund_q == 4'd0 && tens_q == 4'd0) ? 7'h7F : enc(tens_q);
            2'd2:    seg_d = (hund_q == 4'd0) ? 7'h7F : enc(hund_q);
            default: seg_d = 7'h7F;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            idx_q <= '0;
            seg   <= 7'h40;
            an    <= 4'b1110;
            dp    <= 1'b1;
        end else begin
            if (cnt_q == CNT_MAX) begin
                cnt_q <= '0;
                idx_q <= idx_q + 2'd1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            seg <= seg_d;
            an  <= ~(4'b0001 << idx_q);
            dp  <= 1'b1;
        end
    end

endmodule

// File: doc/score_display.md
# score_display

Converts the 7-bit game score (0–127) from the scoring block into decimal and drives a 4-digit, time-multiplexed, common-anode seven-segment display. It sits downstream of the score register in the top-level game datapath, on the same system clock. It re-converts automatically whenever the score changes, using a sequential shift-add-3 (double-dabble) engine. Leading zeros are blanked.

## Interface
- REFRESH_DIV, 100000 — clk cycles each digit stays lit. Must be ≥ 2. Benches use 4.
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset
- score  input  7  current score, unsigned binary 0–127; may change on any cycle
- seg  output  7  segment drive, active-low; bit order {g,f,e,d,c,b,a} = seg[6:0]
- an  output  4  digit anodes, active-low one-hot; an[0]=ones, an[1]=tens, an[2]=hundreds, an[3]=unused (always blank)
- dp  output  1  decimal point, active-low; held 1 (off)
- busy  output  1  high while a conversion is in progress

## Operation
- Latched registers:
  - last_score (7b): value most recently converted
  - hund/tens/ones (4b each): displayed digits
- FSM states:
  - IDLE: if score != last_score, capture score into the shift register and last_score, clear the BCD accumulator, go to SHIFT.
  - SHIFT: 7 iterations, one per cycle. Each cycle, add 3 to any BCD nibble ≥ 5, then shift left by 1, bringing in the binary MSB. After the 7th iteration, go to LOAD.
  - LOAD: copy the accumulator to hund/tens/ones, return to IDLE.
- busy = 1 in SHIFT and LOAD.
- Score changes during SHIFT/LOAD are ignored. IDLE re-compares on the next cycle, so the final displayed value always matches a stable score.
- hund is always 0 or 1; tens and ones are always 0–9. The accumulator needs 10 bits.
- Refresh counter:
  - counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the 2-bit digit index advances 0→1→2→3→0.
- Blanking (seg = 7'h7F):
  - index 3: always blank
  - index 2: blank if hund = 0
  - index 1: blank if hund = 0 and tens = 0
  - index 0: never blank
- Segment codes (hex, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
- seg, an and dp are registered. They reflect the index and digit registers from the previous cycle.

## Timing
- Reset (rst=0, asynchronous) immediately forces:
  - state IDLE, last_score=0, hund/tens/ones=0
  - refresh counter 0, index 0
  - an=4'b1110, seg=7'h40, dp=1, busy=0
- Reset mid-conversion aborts the conversion; the partial result is discarded.
- After release, if score ≠ 0, a conversion starts on the first edge.
- Conversion latency:
  - score change sampled in IDLE at edge N
  - busy=1 after edge N
  - SHIFT at edges N+1..N+7, LOAD at edge N+8, busy=0 after edge N+8
  - digit registers updated at edge N+8
  - seg reflects the new digits at edge N+9
- Refresh timing:
  - an changes one cycle after the index changes
  - each anode is low for exactly REFRESH_DIV cycles
  - full scan = 4·REFRESH_DIV cycles
- Exactly one an bit is low at every cycle after reset.

## Test plan
- Reset: hold rst=0 with score=0 → an=1110, seg=40, dp=1, busy=0. Release, run 16 cycles (REFRESH_DIV=4): busy stays 0; seg=40 only while an=1110, 7F otherwise.
- Single conversion: score 0→5 → busy high for exactly 8 cycles. Then an=1110 gives seg=12, and an=1101/1011/0111 give seg=7F.
- Max value: score=127 →
  - an=1011: seg=79
  - an=1101: seg=24
  - an=1110: seg=78
  - an=0111: seg=7F
- Internal zero: score=100 → an=1011 seg=79, an=1101 seg=40 (not blanked), an=1110 seg=40. Then score=9 → an=1101 and an=1011 blank (7F), an=1110 seg=10.
- Change during busy: score=5, then 42 three cycles later →
  - first conversion completes with ones=5
  - second conversion starts the next cycle; busy drops for exactly 1 cycle between conversions
  - final display: an=1101 seg=19, an=1110 seg=24
- Reset mid-conversion: score=99, rst=0 at cycle 4 of SHIFT → outputs return to reset values asynchronously. Release → reconversion: 8 cycles busy, then an=1101 and an=1110 both seg=10.
